// File: rtl/botao_pkg.sv
// Shared definitions for the pushbutton conditioner: state encoding and default timing.
package botao_pkg;

  // 2-bit FSM encoding.
  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StFiltra   = 2'd1,
    StSoltar   = 2'd2,
    StBloqueio = 2'd3
  } state_e;

  localparam logic [7:0] DEBOUNCE_DEF = 8'd4;
  localparam logic [7:0] LOCKOUT_DEF  = 8'd8;

  // Saturating 8-bit increment.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sincronizador.sv
// Two-flop synchronizer for a single asynchronous level.
module sincronizador (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  // Shift the raw level through two flops; both clear on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/botao_cond.sv
// Pushbutton conditioner: synchronizes, debounces press and release, applies a post-release
// lockout, and hands one pulse per press to the traffic-light controller with a pending flag.
module botao_cond
  import botao_pkg::*;
#(
  parameter logic [7:0] DEBOUNCE = DEBOUNCE_DEF,
  parameter logic [7:0] LOCKOUT  = LOCKOUT_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bt_raw,
  input  logic       ack,
  output logic       bt,
  output logic       pend,
  output logic       busy,
  output logic [7:0] perdidos
);

  logic       w_s;
  logic       w_accept;
  state_e     r_state;
  logic [7:0] r_cnt;
  logic       r_bt;
  logic       r_busy;
  logic       r_pend;
  logic [7:0] r_perdidos;

  sincronizador u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bt_raw),
    .q   (w_s)
  );

  // A press is accepted on the edge where the stable-high count would reach DEBOUNCE.
  // With DEBOUNCE=1 the very first high sample in IDLE already completes the count.
  always_comb begin
    w_accept = 1'b0;
    if (w_s) begin
      if (r_state == StIdle && DEBOUNCE == 8'd1) begin
        w_accept = 1'b1;
      end else if (r_state == StFiltra && r_cnt >= DEBOUNCE - 8'd1) begin
        w_accept = 1'b1;
      end
    end
  end

  // Debounce/lockout FSM with registered bt and busy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= StIdle;
      r_cnt   <= 8'd0;
      r_bt    <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_bt   <= w_accept;
      r_busy <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_state <= StSoltar;
            r_cnt   <= 8'd0;
          end else if (w_s) begin
            r_state <= StFiltra;
            r_cnt   <= 8'd1;
          end else begin
            r_cnt <= 8'd0;
          end
        end
        StFiltra: begin
          if (!w_s) begin
            r_state <= StIdle;
            r_cnt   <= 8'd0;
          end else if (w_accept) begin
            r_state <= StSoltar;
            r_cnt   <= 8'd0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        StSoltar: begin
          // Any high sample restarts the release count, so a held button never re-fires.
          if (w_s) begin
            r_cnt <= 8'd0;
          end else if (r_cnt >= DEBOUNCE - 8'd1) begin
            if (LOCKOUT == 8'd0) begin
              r_state <= StIdle;
              r_cnt   <= 8'd0;
            end else begin
              r_state <= StBloqueio;
              r_cnt   <= LOCKOUT;
              r_busy  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        StBloqueio: begin
          // Input ignored; leave on the edge that sees cnt=1.
          if (r_cnt <= 8'd1) begin
            r_state <= StIdle;
            r_cnt   <= 8'd0;
          end else begin
            r_cnt  <= r_cnt - 8'd1;
            r_busy <= 1'b1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_cnt   <= 8'd0;
        end
      endcase
    end
  end

  // Pending request and lost-press counter; a new press wins over a simultaneous ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend     <= 1'b0;
      r_perdidos <= 8'd0;
    end else begin
      if (w_accept) begin
        r_pend <= 1'b1;
      end else if (ack) begin
        r_pend <= 1'b0;
      end
      if (w_accept && r_pend) begin
        r_perdidos <= sat_inc(r_perdidos);
      end
    end
  end

  assign bt       = r_bt;
  assign pend     = r_pend;
  assign busy     = r_busy;
  assign perdidos = r_perdidos;

endmodule

// File: tb/tb_botao_cond.sv
// Scoreboard bench for botao_cond: each driven press queues its expected bt cycle and perdidos.
module tb_botao_cond;
  import botao_pkg::*;

  localparam int D = 4;
  localparam int L = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       bt_raw;
  logic       ack;
  logic       bt;
  logic       pend;
  logic       busy;
  logic [7:0] perdidos;

  botao_cond #(
    .DEBOUNCE (8'(D)),
    .LOCKOUT  (8'(L))
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bt_raw   (bt_raw),
    .ack      (ack),
    .bt       (bt),
    .pend     (pend),
    .busy     (busy),
    .perdidos (perdidos)
  );

  always #5 clk = ~clk;

  // Rising-edge count; at a negedge, cyc is the number of the edge just taken.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int perd;
  } exp_t;

  exp_t sb[$];
  int   n_checks  = 0;
  int   n_errors  = 0;
  int   exp_perd  = 0;
  bit   exp_pend  = 1'b0;
  int   busy_rise = -1;
  int   busy_fall = -1;
  logic busy_prev = 1'b0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Output monitor: busy edges and scoreboard pops on every bt pulse.
  always @(negedge clk) begin
    if (busy === 1'b1 && busy_prev !== 1'b1) busy_rise = cyc;
    if (busy !== 1'b1 && busy_prev === 1'b1) busy_fall = cyc;
    busy_prev = busy;
    if (sb.size() > 0 && cyc > sb[0].cyc) begin
      check("bt_missing", cyc, sb[0].cyc);
      void'(sb.pop_front());
    end
    if (bt === 1'b1) begin
      if (sb.size() == 0) begin
        check("bt_spurious", int'(bt), 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("bt_cycle", cyc, e.cyc);
        check("perdidos_on_bt", int'(perdidos), e.perd);
        check("pend_on_bt", int'(pend), 1);
      end
    end
  end

  // Clean press held for 'hold' edges from an idle FSM; optional ack on the bt edge and an
  // optional second press poked in while locked out.
  task automatic press(input int hold, input bit ack_on_bt, input bit poke_busy);
    int   n;
    int   r;
    exp_t e;
    @(negedge clk);
    bt_raw    = 1'b1;
    n         = cyc + 1;
    busy_rise = -1;
    busy_fall = -1;
    if (exp_pend) exp_perd = (exp_perd < 255) ? exp_perd + 1 : 255;
    exp_pend = 1'b1;
    e.cyc    = n + D + 1;
    e.perd   = exp_perd;
    sb.push_back(e);
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      ack = ack_on_bt && (i == D + 1);
    end
    @(negedge clk);
    bt_raw = 1'b0;
    ack    = 1'b0;
    r      = n + hold;
    while (cyc < r + D + 1) @(negedge clk);
    if (poke_busy) begin
      bt_raw = 1'b1;
      repeat (4) @(negedge clk);
      bt_raw = 1'b0;
    end
    while (cyc < r + D + L + 3) @(negedge clk);
    check("busy_rise", busy_rise, r + D + 1);
    check("busy_fall", busy_fall, r + D + L + 1);
    check("perdidos_idle", int'(perdidos), exp_perd);
    check("pend_idle", int'(pend), int'(exp_pend));
  endtask

  task automatic do_ack();
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack      = 1'b0;
    exp_pend = 1'b0;
    check("pend_after_ack", int'(pend), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish (edge %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int   n;
    int   m;
    exp_t e;
    logic [7:0] bounce;

    // Reset with the button held: outputs clear before any clock edge.
    rst    = 1'b0;
    bt_raw = 1'b1;
    ack    = 1'b0;
    #1;
    check("rst_bt", int'(bt), 0);
    check("rst_pend", int'(pend), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_perdidos", int'(perdidos), 0);
    repeat (3) @(negedge clk);
    check("rst_bt_clocked", int'(bt), 0);
    bt_raw = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Long hold: one pulse, lockout after release.
    press(10, 1'b0, 1'b0);
    do_ack();
    do_ack();

    // Ack on the bt edge leaves pend set.
    press(10, 1'b1, 1'b0);

    // Press with pend=1 is lost; press during lockout is ignored.
    press(6, 1'b0, 1'b1);
    press(D, 1'b0, 1'b0);

    // Bounce: two 3-sample bursts never reach the debounce count.
    busy_rise = -1;
    bounce    = 8'b1110_1110;
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      bt_raw = bounce[i];
    end
    @(negedge clk);
    bt_raw = 1'b0;
    repeat (D + 4) @(negedge clk);
    check("bounce_no_busy", busy_rise, -1);
    check("bounce_state_idle", int'(dut.r_state), int'(StIdle));

    // Saturation of the lost-press counter.
    for (int k = 0; k < 300; k++) press(D, 1'b0, 1'b0);
    check("perdidos_sat", int'(perdidos), 255);

    // Reset at cnt=2 in FILTRA while held: aborted press is dropped, held button restarts.
    @(negedge clk);
    bt_raw = 1'b1;
    n      = cyc + 1;
    while (cyc < n + 3) @(negedge clk);
    check("filtra_cnt2", int'(dut.r_cnt), 2);
    rst = 1'b0;
    #1;
    check("midrst_bt", int'(bt), 0);
    check("midrst_pend", int'(pend), 0);
    check("midrst_perdidos", int'(perdidos), 0);
    exp_perd = 0;
    exp_pend = 1'b0;
    repeat (2) @(negedge clk);
    rst    = 1'b1;
    m      = cyc;
    e.cyc  = m + D + 2;
    e.perd = 0;
    sb.push_back(e);
    exp_pend = 1'b1;
    repeat (10) @(negedge clk);
    bt_raw = 1'b0;
    repeat (2 * D + L + 6) @(negedge clk);
    check("post_rst_pend", int'(pend), 1);
    check("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
